// File: rtl/bus_pkg.sv
// Shared types and constants for the bit-serial bus slave controller.
package bus_pkg;

    localparam int unsigned DEF_ADDR_W  = 12;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam int unsigned RD_LATENCY  = 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RREQ,
        RWAIT,
        RDATA
    } state_e;

    // Bit counter width: enough for the longer serial phase, plus one spare bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/serial_slave_ctrl_if.sv
// Bit-serial bus signals between the arbiter slave port and the slave controller.
interface serial_slave_ctrl_if;
    logic address;
    logic data;
    logic valid;
    logic address_valid;
    logic write_en;
    logic ready;
    logic data_out;
    logic valid_out;

    modport master (
        output address, data, valid, address_valid, write_en,
        input  ready, data_out, valid_out
    );

    modport slave (
        input  address, data, valid, address_valid, write_en,
        output ready, data_out, valid_out
    );
endinterface

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: serial-in/parallel-out, or parallel-load/serial-out.
module serial_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         sin,
    input  logic         load_en,
    input  logic [W-1:0] pdata,
    output logic [W-1:0] q,
    output logic         sout
);

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load_en) begin
            q <= pdata;
        end else if (shift_en) begin
            q <= {sin, q[W-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/serial_slave_ctrl.sv
// Slave-side transaction controller for the bit-serial bus.
// Optional idle-valid abort enabled by defining SERIAL_SLAVE_TIMEOUT_EN.
module serial_slave_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    serial_slave_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    localparam int unsigned CNT_W = cnt_width(ADDR_W, DATA_W);

    state_e             state;
    logic               we_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ready_q;
    logic               valid_out_q;
    logic               data_out_q;
    logic               timeout_hit_c;
    logic               addr_shift_c;
    logic               wdata_shift_c;
    logic               rd_load_c;
    logic               rd_shift_c;
    logic               unused_addr_sout;
    logic               unused_wdata_sout;
    logic [DATA_W-1:0]  unused_rd_q;

    // A start strobe takes priority over bit sampling in the same cycle.
    assign addr_shift_c  = (state == ADDR)  && bus.valid && !bus.address_valid;
    assign wdata_shift_c = (state == WDATA) && bus.valid && !bus.address_valid;
    assign rd_load_c     = (state == RWAIT) && (bit_cnt == CNT_W'(RD_LATENCY - 1));
    assign rd_shift_c    = (state == RDATA);

    serial_shift_reg #(.W(ADDR_W)) u_addr_sr (
        .clk      (clk),
        .rst_n    (reset),
        .shift_en (addr_shift_c),
        .sin      (bus.address),
        .load_en  (1'b0),
        .pdata    ('0),
        .q        (mem_addr),
        .sout     (unused_addr_sout)
    );

    serial_shift_reg #(.W(DATA_W)) u_wdata_sr (
        .clk      (clk),
        .rst_n    (reset),
        .shift_en (wdata_shift_c),
        .sin      (bus.data),
        .load_en  (1'b0),
        .pdata    ('0),
        .q        (mem_wdata),
        .sout     (unused_wdata_sout)
    );

    // Zero fill leaves data_out low once the read word has been sent.
    serial_shift_reg #(.W(DATA_W)) u_rdata_sr (
        .clk      (clk),
        .rst_n    (reset),
        .shift_en (rd_shift_c),
        .sin      (1'b0),
        .load_en  (rd_load_c),
        .pdata    (mem_rdata),
        .q        (unused_rd_q),
        .sout     (data_out_q)
    );

`ifdef SERIAL_SLAVE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT) + 1;

    logic [TO_W-1:0] idle_cnt;
    logic            in_xfer_c;

    assign in_xfer_c     = (state == ADDR) || (state == WDATA);
    assign timeout_hit_c = in_xfer_c && !bus.address_valid && !bus.valid &&
                           (idle_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!in_xfer_c || bus.valid || bus.address_valid || timeout_hit_c) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign timeout_hit_c  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            bit_cnt     <= '0;
            ready_q     <= 1'b1;
            valid_out_q <= 1'b0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: if (bus.address_valid) begin
                    we_q    <= bus.write_en;
                    bit_cnt <= '0;
                    ready_q <= 1'b0;
                    state   <= ADDR;
                end
                ADDR, WDATA: begin
                    if (bus.address_valid) begin
                        we_q    <= bus.write_en;
                        bit_cnt <= '0;
                        state   <= ADDR;
                    end else if (timeout_hit_c) begin
                        bit_cnt <= '0;
                        ready_q <= 1'b1;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else if (bus.valid) begin
                        if (state == ADDR && bit_cnt == CNT_W'(ADDR_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= we_q ? WDATA : RREQ;
                            mem_re  <= !we_q;
                        end else if (state == WDATA && bit_cnt == CNT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= WRITE;
                            mem_we  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                RREQ: begin
                    bit_cnt <= '0;
                    state   <= RWAIT;
                end
                RWAIT: if (rd_load_c) begin
                    bit_cnt     <= '0;
                    valid_out_q <= 1'b1;
                    state       <= RDATA;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                RDATA: if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    bit_cnt     <= '0;
                    valid_out_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                default: begin
                    bit_cnt     <= '0;
                    valid_out_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_serial_slave_ctrl.sv
// Self-checking bench for serial_slave_ctrl: vector table, corner sequences, random traffic.
// Timeout sequence selected by SERIAL_SLAVE_TIMEOUT_EN, matching the RTL build.
module tb_serial_slave_ctrl;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              mem_re;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int err_cnt  = 0;

    logic [DATA_W-1:0] dev_mem [4096];
    logic [DATA_W-1:0] ref_mem [4096];

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rd;
        int                stall_at;
        int                stall_len;
        int                abort_bits;
        int                av_at;
    } vec_t;

    vec_t vecs [11];
    logic [ADDR_W-1:0] pool [8];

    serial_slave_ctrl_if bus_if();

    serial_slave_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input int unsigned a);
        return (a == 32'h0F0) ? 8'hC6 : 8'(a * 37 + 11);
    endfunction

    // Memory model: read data valid the cycle after mem_re, garbage otherwise.
    initial begin
        for (int i = 0; i < 4096; i++) dev_mem[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_re) mem_rdata <= dev_mem[mem_addr];
            else        mem_rdata <= 8'($urandom);
            if (mem_we) dev_mem[mem_addr] = mem_wdata;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
        if (err)    err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [DATA_W-1:0] exp_rd, input int stall_at, input int stall_len,
                           input int abort_bits, input int av_at);
        int we0;
        int re0;
        int nbits;
        logic [ADDR_W+DATA_W-1:0] bits;
        we0   = we_cnt;
        re0   = re_cnt;
        bits  = {d, a};
        nbits = ADDR_W + (we ? DATA_W : 0);
        if (abort_bits == 0) begin
            check("ready_idle", 32'(bus_if.ready), 32'd1);
        end else begin
            bus_if.address_valid = 1'b1;
            bus_if.write_en      = ~we;
            bus_if.valid         = 1'b0;
            @(negedge clk);
            bus_if.address_valid = 1'b0;
            for (int i = 0; i < abort_bits; i++) begin
                bus_if.valid   = 1'b1;
                bus_if.address = 1'($urandom);
                bus_if.data    = 1'($urandom);
                @(negedge clk);
            end
            check("busy_before_restart", 32'(bus_if.ready), 32'd0);
        end
        // Strobe with valid high and a wrong address bit: it must not be sampled.
        bus_if.address_valid = 1'b1;
        bus_if.write_en      = we;
        bus_if.valid         = 1'b1;
        bus_if.address       = ~a[0];
        @(negedge clk);
        bus_if.address_valid = 1'b0;
        bus_if.write_en      = 1'($urandom);
        check("busy", 32'(bus_if.ready), 32'd0);
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus_if.valid   = 1'b0;
                    bus_if.address = 1'($urandom);
                    bus_if.data    = 1'($urandom);
                    @(negedge clk);
                end
            end
            bus_if.valid   = 1'b1;
            bus_if.address = (i < ADDR_W) ? bits[i] : 1'($urandom);
            bus_if.data    = (i >= ADDR_W) ? bits[i] : 1'($urandom);
            @(negedge clk);
        end
        bus_if.valid = 1'b0;
        if (we) begin
            check("mem_we", 32'(mem_we), 32'd1);
            check("mem_addr", 32'(mem_addr), 32'(a));
            check("mem_wdata", 32'(mem_wdata), 32'(d));
            check("write_busy", 32'(bus_if.ready), 32'd0);
            @(negedge clk);
            check("mem_we_end", 32'(mem_we), 32'd0);
            check("write_ready", 32'(bus_if.ready), 32'd1);
        end else begin
            check("mem_re", 32'(mem_re), 32'd1);
            check("rd_addr", 32'(mem_addr), 32'(a));
            check("valid_out_early", 32'(bus_if.valid_out), 32'd0);
            @(negedge clk);
            check("mem_re_end", 32'(mem_re), 32'd0);
            check("valid_out_early2", 32'(bus_if.valid_out), 32'd0);
            for (int k = 0; k < DATA_W; k++) begin
                @(negedge clk);
                check("valid_out", 32'(bus_if.valid_out), 32'd1);
                check("data_out", 32'(bus_if.data_out), 32'(exp_rd[k]));
                bus_if.address_valid = (k == av_at);
                bus_if.write_en      = 1'($urandom);
            end
            @(negedge clk);
            bus_if.address_valid = 1'b0;
            check("valid_out_end", 32'(bus_if.valid_out), 32'd0);
            check("read_ready", 32'(bus_if.ready), 32'd1);
        end
        check("we_count", 32'(we_cnt - we0), 32'(we));
        check("re_count", 32'(re_cnt - re0), 32'(!we));
    endtask

    initial begin
        reset                = 1'b0;
        bus_if.address       = 1'b0;
        bus_if.data          = 1'b0;
        bus_if.valid         = 1'b0;
        bus_if.address_valid = 1'b0;
        bus_if.write_en      = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);

        vecs[0]  = '{1'b1, 12'h5A5, 8'hB3, 8'h00, -1, 0, 0, -1};
        vecs[1]  = '{1'b0, 12'h0F0, 8'h00, 8'hC6, -1, 0, 0, -1};
        vecs[2]  = '{1'b1, 12'h123, 8'h5C, 8'h00,  6, 5, 0, -1};
        vecs[3]  = '{1'b0, 12'h123, 8'h00, 8'h5C, -1, 0, 0, -1};
        vecs[4]  = '{1'b0, 12'h5A5, 8'h00, 8'hB3, -1, 0, 0,  4};
        vecs[5]  = '{1'b1, 12'hFFF, 8'h00, 8'h00, 15, 2, 0, -1};
        vecs[6]  = '{1'b1, 12'h000, 8'hFF, 8'h00, -1, 0, 6, -1};
        vecs[7]  = '{1'b0, 12'hFFF, 8'h00, 8'h00, -1, 0, 6, -1};
        vecs[8]  = '{1'b0, 12'h000, 8'h00, 8'hFF, 11, 3, 0, -1};
        vecs[9]  = '{1'b1, 12'h800, 8'hA5, 8'h00,  0, 2, 0, -1};
        vecs[10] = '{1'b0, 12'h800, 8'h00, 8'hA5, -1, 0, 0,  7};

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus_if.ready), 32'd1);
        check("rst_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("rst_data_out", 32'(bus_if.data_out), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            run_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd,
                    vecs[v].stall_at, vecs[v].stall_len, vecs[v].abort_bits, vecs[v].av_at);
            if (vecs[v].we) ref_mem[vecs[v].addr] = vecs[v].wdata;
        end

        // Asynchronous reset part-way through the write data.
        begin
            int we0;
            int re0;
            we0 = we_cnt;
            re0 = re_cnt;
            bus_if.address_valid = 1'b1;
            bus_if.write_en      = 1'b1;
            bus_if.valid         = 1'b0;
            @(negedge clk);
            bus_if.address_valid = 1'b0;
            for (int i = 0; i < ADDR_W + 4; i++) begin
                bus_if.valid   = 1'b1;
                bus_if.address = 1'($urandom);
                bus_if.data    = 1'($urandom);
                @(negedge clk);
            end
            #2 reset = 1'b0;
            #1;
            check("async_rst_ready", 32'(bus_if.ready), 32'd1);
            check("async_rst_mem_addr", 32'(mem_addr), 32'd0);
            check("async_rst_mem_wdata", 32'(mem_wdata), 32'd0);
            check("async_rst_mem_we", 32'(mem_we), 32'd0);
            check("async_rst_valid_out", 32'(bus_if.valid_out), 32'd0);
            bus_if.valid = 1'b0;
            #1 reset = 1'b1;
            repeat (20) @(negedge clk);
            check("post_rst_we_count", 32'(we_cnt - we0), 32'd0);
            check("post_rst_re_count", 32'(re_cnt - re0), 32'd0);
            check("post_rst_ready", 32'(bus_if.ready), 32'd1);
        end

`ifdef SERIAL_SLAVE_TIMEOUT_EN
        begin
            int we0;
            int re0;
            int e0;
            we0 = we_cnt;
            re0 = re_cnt;
            e0  = err_cnt;
            bus_if.address_valid = 1'b1;
            bus_if.write_en      = 1'b0;
            bus_if.valid         = 1'b0;
            @(negedge clk);
            bus_if.address_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                bus_if.valid   = 1'b1;
                bus_if.address = 1'($urandom);
                @(negedge clk);
            end
            bus_if.valid = 1'b0;
            for (int i = 1; i <= 17; i++) begin
                @(negedge clk);
                if (i == 15) begin
                    check("to_err_before", 32'(err), 32'd0);
                    check("to_busy_before", 32'(bus_if.ready), 32'd0);
                end
                if (i == 16) begin
                    check("to_err_pulse", 32'(err), 32'd1);
                    check("to_ready", 32'(bus_if.ready), 32'd1);
                end
                if (i == 17) check("to_err_end", 32'(err), 32'd0);
            end
            check("to_err_count", 32'(err_cnt - e0), 32'd1);
            check("to_we_count", 32'(we_cnt - we0), 32'd0);
            check("to_re_count", 32'(re_cnt - re0), 32'd0);
        end
`else
        run_txn(1'b0, 12'h0F0, 8'h00, ref_mem[12'h0F0], 3, 20, 0, -1);
        check("no_timeout_err_count", 32'(err_cnt), 32'd0);
`endif

        for (int i = 0; i < 8; i++) pool[i] = 12'($urandom);
        for (int n = 0; n < 40; n++) begin
            bit                we;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            int                sa;
            int                sl;
            int                ab;
            int                av;
            we = 1'($urandom);
            a  = pool[$urandom_range(0, 7)];
            d  = 8'($urandom);
            sl = $urandom_range(0, 6);
            sa = (sl == 0) ? -1 : $urandom_range(0, ADDR_W + DATA_W - 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ADDR_W - 1) : 0;
            av = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DATA_W - 1) : -1;
            run_txn(we, a, d, ref_mem[a], sa, sl, ab, av);
            if (we) ref_mem[a] = d;
        end
        check("final_err_count", 32'(err_cnt),
`ifdef SERIAL_SLAVE_TIMEOUT_EN
              32'd1
`else
              32'd0
`endif
        );

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
